// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg
//
// Shared definitions for the MIPS instruction packer:
//   - fmt_e    : instruction format selector (R / I / J / reserved)
//   - state_e  : packer session state (IDLE / LOAD / DONE)
//   - field width constants for the MIPS encoding
//   - NOP_WORD : word emitted for the reserved format
//   - field_is_bad() : classifies tuples that must not reach IM when
//                      field checking is compiled in
// ---------------------------------------------------------------------------
package instr_pkg;

    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;
    localparam int IMM16_W = 16;
    localparam int IMM26_W = 26;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // A genuine R-type always carries opcode 0 (SPECIAL); anything else
    // tagged as R, or a tuple in the reserved format, is malformed.
    function automatic logic field_is_bad(input logic [1:0] fmt,
                                          input logic [OP_W-1:0] op);
        logic bad;
        bad = 1'b0;
        if (fmt_e'(fmt) == FMT_RSV)
            bad = 1'b1;
        else if ((fmt_e'(fmt) == FMT_R) && (op != '0))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/instr_pack_comb.sv
// ---------------------------------------------------------------------------
// instr_pack_comb
//
// Purely combinational fields-to-word packer; the exact inverse of the
// instruction field splitter, so the pair can be used for round-trip checks.
//
// Ports:
//   fmt    in  2   format (0=R, 1=I, 2=J, 3=reserved -> NOP)
//   op     in  6   opcode
//   rs     in  5   rs register field
//   rt     in  5   rt register field
//   rd     in  5   rd register field (R only)
//   shamt  in  5   shift amount (R only)
//   funct  in  6   function code (R only)
//   imm16  in  16  immediate (I only)
//   imm26  in  26  jump target (J only)
//   word   out 32  packed instruction word
// ---------------------------------------------------------------------------
module instr_pack_comb
    import instr_pkg::*;
(
    input  logic [1:0]         fmt,
    input  logic [OP_W-1:0]    op,
    input  logic [REG_W-1:0]   rs,
    input  logic [REG_W-1:0]   rt,
    input  logic [REG_W-1:0]   rd,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [IMM16_W-1:0] imm16,
    input  logic [IMM26_W-1:0] imm26,
    output logic [31:0]        word
);

    // Field placement follows the standard MIPS32 layouts; the reserved
    // format collapses to a NOP so a stray tuple can never become a live
    // instruction in memory.
    always_comb begin
        word = NOP_WORD;
        case (fmt_e'(fmt))
            FMT_R:   word = {op, rs, rt, rd, shamt, funct};
            FMT_I:   word = {op, rs, rt, imm16};
            FMT_J:   word = {op, imm26};
            default: word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_packer.sv
// ---------------------------------------------------------------------------
// instr_packer
//
// Accepts decoded MIPS field tuples over a valid/ready handshake, packs each
// into a 32-bit instruction word and writes the words sequentially into the
// instruction-memory load port, starting at a programmable byte base.
// Used by the bench / boot loader to preload programs for P4/P5 CPU runs.
//
// Parameters:
//   DEPTH      maximum words per load session (power of two)
//   BASE_ADDR  default base byte address (start_base_sel = 0)
//
// Ports:
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   start           in   one-cycle pulse, begins a session (IDLE only)
//   start_base_sel  in   0: BASE_ADDR, 1: start_base (sampled with start)
//   start_base      in   alternate base, bits [1:0] forced to 0
//   in_valid/in_ready/in_last   tuple handshake and end-of-session marker
//   in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct,
//   in_imm16, in_imm26          decoded instruction fields
//   im_we, im_addr, im_wdata    IM write port (one cycle after handshake)
//   word_count      words written in this session
//   busy            session active
//   done            one-cycle pulse with the final write
//   overflow        sticky: session ended at DEPTH without in_last
//   bad_field       (only with INSTR_PACKER_FIELD_CHECK_EN) sticky: a
//                   malformed tuple was dropped this session
//
// Build option:
//   INSTR_PACKER_FIELD_CHECK_EN  drop R tuples with op!=0 and reserved-format
//                                tuples instead of writing them.
// ---------------------------------------------------------------------------
module instr_packer
    import instr_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     start_base_sel,
    input  logic [31:0]              start_base,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [1:0]               in_fmt,
    input  logic [OP_W-1:0]          in_op,
    input  logic [REG_W-1:0]         in_rs,
    input  logic [REG_W-1:0]         in_rt,
    input  logic [REG_W-1:0]         in_rd,
    input  logic [SHAMT_W-1:0]       in_shamt,
    input  logic [FUNCT_W-1:0]       in_funct,
    input  logic [IMM16_W-1:0]       in_imm16,
    input  logic [IMM26_W-1:0]       in_imm26,
    output logic                     im_we,
    output logic [31:0]              im_addr,
    output logic [31:0]              im_wdata,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
`ifdef INSTR_PACKER_FIELD_CHECK_EN
   ,output logic                     bad_field
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    state_e state;
    state_e next_state;

    logic [31:0]      addr_ptr;
    logic [31:0]      packed_word;
    logic [CNT_W-1:0] next_count;
    logic             accept;
    logic             write_ok;
    logic             hit_depth;
    logic             finish;

    instr_pack_comb u_pack (
        .fmt   (in_fmt),
        .op    (in_op),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .shamt (in_shamt),
        .funct (in_funct),
        .imm16 (in_imm16),
        .imm26 (in_imm26),
        .word  (packed_word)
    );

    assign accept     = in_valid & in_ready;
    assign next_count = word_count + CNT_W'(1);

`ifdef INSTR_PACKER_FIELD_CHECK_EN
    assign write_ok = ~field_is_bad(in_fmt, in_op);
`else
    assign write_ok = 1'b1;
`endif

    // Only a tuple that is actually written can fill the session, so a
    // dropped tuple never trips the DEPTH limit.
    assign hit_depth = write_ok & (next_count == DEPTH_CNT);
    assign finish    = in_last | hit_depth;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; in_ready is purely a function of the state so the
    // upstream side sees a stable ready for the whole LOAD phase.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (accept && finish)
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Session datapath: address pointer, registered IM write port, counters
    // and status flags. im_we and done are single-cycle pulses, so they
    // default low every cycle and are only raised by a handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_ptr   <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef INSTR_PACKER_FIELD_CHECK_EN
            bad_field  <= 1'b0;
`endif
        end else begin
            im_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_ptr   <= start_base_sel ? (start_base & 32'hFFFF_FFFC)
                                                     : BASE_ADDR;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
`ifdef INSTR_PACKER_FIELD_CHECK_EN
                        bad_field  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (write_ok) begin
                            im_we      <= 1'b1;
                            im_addr    <= addr_ptr;
                            im_wdata   <= packed_word;
                            addr_ptr   <= addr_ptr + 32'd4;
                            word_count <= next_count;
                        end
`ifdef INSTR_PACKER_FIELD_CHECK_EN
                        else begin
                            bad_field <= 1'b1;
                        end
`endif
                        if (finish)
                            done <= 1'b1;
                        // A last tuple that also fills the session is a
                        // clean finish, not an overflow.
                        if (hit_depth && !in_last)
                            overflow <= 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_packer.sv
// ---------------------------------------------------------------------------
// tb_instr_packer
//
// Self-checking bench for instr_packer (DEPTH=4 so the session limit is
// reachable). Expected words come from a reference model that builds the
// instruction word arithmetically from the MIPS field weights; expected
// addresses come from base + 4*index.
// ---------------------------------------------------------------------------
module tb_instr_packer;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] BASE_ADDR = 32'h0000_3000;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] i16;
        logic [25:0] i26;
    } tuple_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        start_base_sel;
    logic [31:0] start_base;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  in_fmt;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm16;
    logic [25:0] in_imm26;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic [2:0]  word_count;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef INSTR_PACKER_FIELD_CHECK_EN
    logic        bad_field;
`endif

    int checks = 0;
    int errors = 0;

    instr_packer #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .start_base_sel (start_base_sel),
        .start_base     (start_base),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_last        (in_last),
        .in_fmt         (in_fmt),
        .in_op          (in_op),
        .in_rs          (in_rs),
        .in_rt          (in_rt),
        .in_rd          (in_rd),
        .in_shamt       (in_shamt),
        .in_funct       (in_funct),
        .in_imm16       (in_imm16),
        .in_imm26       (in_imm26),
        .im_we          (im_we),
        .im_addr        (im_addr),
        .im_wdata       (im_wdata),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
`ifdef INSTR_PACKER_FIELD_CHECK_EN
       ,.bad_field      (bad_field)
`endif
    );

    // Free-running clock, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: weight each field by its bit position.
    function automatic logic [31:0] model_word(input tuple_t t);
        longint w;
        case (t.fmt)
            2'd0: w = t.op * 64'd67108864 + t.rs * 64'd2097152 + t.rt * 64'd65536
                      + t.rd * 64'd2048 + t.sh * 64'd64 + t.fn;
            2'd1: w = t.op * 64'd67108864 + t.rs * 64'd2097152 + t.rt * 64'd65536
                      + t.i16;
            2'd2: w = t.op * 64'd67108864 + t.i26;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic tuple_t make_tuple(input int fmt, input int op, input int rs,
                                          input int rt, input int rd, input int sh,
                                          input int fn, input int i16, input int i26);
        tuple_t t;
        t.fmt = fmt[1:0]; t.op = op[5:0]; t.rs = rs[4:0]; t.rt = rt[4:0];
        t.rd = rd[4:0]; t.sh = sh[4:0]; t.fn = fn[5:0]; t.i16 = i16[15:0];
        t.i26 = i26[25:0];
        return t;
    endfunction

    function automatic tuple_t rand_tuple();
        tuple_t t;
        t.fmt = 2'($urandom_range(0, 3));
        t.op  = 6'($urandom);
        t.rs  = 5'($urandom);
        t.rt  = 5'($urandom);
        t.rd  = 5'($urandom);
        t.sh  = 5'($urandom);
        t.fn  = 6'($urandom);
        t.i16 = 16'($urandom);
        t.i26 = 26'($urandom);
`ifdef INSTR_PACKER_FIELD_CHECK_EN
        t.fmt = 2'($urandom_range(0, 2));
        if (t.fmt == 2'd0) t.op = '0;
`endif
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_cycle(input string tag);
        check_output({tag, "_we"},   {31'd0, im_we}, 32'd0);
        check_output({tag, "_done"}, {31'd0, done},  32'd0);
    endtask

    task automatic apply_start(input logic sel, input logic [31:0] base);
        start = 1'b1; start_base_sel = sel; start_base = base;
        tick();
        start = 1'b0;
        check_output("start_busy",  {31'd0, busy},     32'd1);
        check_output("start_ready", {31'd0, in_ready}, 32'd1);
        check_output("start_count", {29'd0, word_count}, 32'd0);
        check_output("start_ovf",   {31'd0, overflow}, 32'd0);
        check_output("start_we",    {31'd0, im_we},    32'd0);
    endtask

    // Present one tuple and return just after the edge that accepts it.
    task automatic apply_stimulus(input tuple_t t, input logic last);
        in_fmt = t.fmt; in_op = t.op; in_rs = t.rs; in_rt = t.rt; in_rd = t.rd;
        in_shamt = t.sh; in_funct = t.fn; in_imm16 = t.i16; in_imm26 = t.i26;
        in_last = last; in_valid = 1'b1;
        for (int w = 0; w < 20 && !in_ready; w++) tick();
        check_output("ready_wait", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] word,
                                input int count, input logic exp_done,
                                input logic exp_ovf);
        check_output("wr_we",    {31'd0, im_we},    32'd1);
        check_output("wr_addr",  im_addr,           addr);
        check_output("wr_data",  im_wdata,          word);
        check_output("wr_count", {29'd0, word_count}, 32'(count));
        check_output("wr_done",  {31'd0, done},     {31'd0, exp_done});
        check_output("wr_ovf",   {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    task automatic expect_session_end();
        tick();
        check_output("end_busy",  {31'd0, busy},     32'd0);
        check_output("end_ready", {31'd0, in_ready}, 32'd0);
        check_idle_cycle("end");
    endtask

    initial begin
        tuple_t t;
        tuple_t tq[$];
        logic [31:0] base;
        logic        sel;
        int          n;

        reset_n = 1'b0; start = 1'b0; start_base_sel = 1'b0; start_base = '0;
        in_valid = 1'b0; in_last = 1'b0; in_fmt = '0; in_op = '0; in_rs = '0;
        in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0; in_imm16 = '0;
        in_imm26 = '0;

        // Reset values.
        #12;
        check_output("rst_we",    {31'd0, im_we},    32'd0);
        check_output("rst_addr",  im_addr,           32'd0);
        check_output("rst_data",  im_wdata,          32'd0);
        check_output("rst_count", {29'd0, word_count}, 32'd0);
        check_output("rst_busy",  {31'd0, busy},     32'd0);
        check_output("rst_ready", {31'd0, in_ready}, 32'd0);
        check_output("rst_done",  {31'd0, done},     32'd0);
        check_output("rst_ovf",   {31'd0, overflow}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Default base, R / I / J program with the literal encodings.
        $display("[TB] default base program");
        apply_start(1'b0, 32'h0);
        apply_stimulus(make_tuple(0, 0, 8, 9, 10, 0, 'h20, 0, 0), 1'b0);
        expect_write(32'h3000, 32'h0109_5020, 1, 1'b0, 1'b0);
        apply_stimulus(make_tuple(1, 'h0D, 0, 8, 0, 0, 0, 'h1234, 0), 1'b0);
        expect_write(32'h3004, 32'h3408_1234, 2, 1'b0, 1'b0);
        apply_stimulus(make_tuple(2, 'h02, 0, 0, 0, 0, 0, 0, 'h0000C00), 1'b1);
        expect_write(32'h3008, 32'h0800_0C00, 3, 1'b1, 1'b0);
        expect_session_end();

        // Alternate base with low bits ignored.
        $display("[TB] alternate base");
        apply_start(1'b1, 32'h0000_0103);
        apply_stimulus(make_tuple(3, 'h3F, 1, 2, 3, 4, 5, 6, 7), 1'b1);
        expect_write(32'h0000_0100, 32'h0, 1, 1'b1, 1'b0);
        expect_session_end();

        // Valid toggling 1,0,1 with a start pulse that must be ignored.
        $display("[TB] valid toggling");
        apply_start(1'b0, 32'h0);
        t = rand_tuple();
        apply_stimulus(t, 1'b0);
        expect_write(32'h3000, model_word(t), 1, 1'b0, 1'b0);
        start = 1'b1; start_base_sel = 1'b1; start_base = 32'h0000_0500;
        tick();
        start = 1'b0;
        check_idle_cycle("gap");
        check_output("gap_busy", {31'd0, busy}, 32'd1);
        t = rand_tuple();
        apply_stimulus(t, 1'b1);
        expect_write(32'h3004, model_word(t), 2, 1'b1, 1'b0);
        expect_session_end();

        // Address wrap modulo 2^32.
        $display("[TB] address wrap");
        apply_start(1'b1, 32'hFFFF_FFFE);
        t = rand_tuple();
        apply_stimulus(t, 1'b0);
        expect_write(32'hFFFF_FFFC, model_word(t), 1, 1'b0, 1'b0);
        t = rand_tuple();
        apply_stimulus(t, 1'b1);
        expect_write(32'h0000_0000, model_word(t), 2, 1'b1, 1'b0);
        expect_session_end();

        // DEPTH reached without in_last: overflow and done on word 4.
        $display("[TB] overflow");
        apply_start(1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            t = rand_tuple();
            apply_stimulus(t, 1'b0);
            expect_write(BASE_ADDR + 32'(4 * i), model_word(t), i + 1,
                         (i == DEPTH - 1), (i == DEPTH - 1));
        end
        in_valid = 1'b1;
        check_output("ovf_ready_done", {31'd0, in_ready}, 32'd0);
        tick();
        check_output("ovf_ready_idle", {31'd0, in_ready}, 32'd0);
        check_output("ovf_sticky",     {31'd0, overflow}, 32'd1);
        check_output("ovf_busy",       {31'd0, busy},     32'd0);
        check_idle_cycle("ovf_idle");
        tick();
        check_idle_cycle("ovf_idle2");
        in_valid = 1'b0;

        // in_last on word DEPTH: clean finish.
        $display("[TB] last at depth");
        apply_start(1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            t = rand_tuple();
            apply_stimulus(t, (i == DEPTH - 1));
            expect_write(BASE_ADDR + 32'(4 * i), model_word(t), i + 1,
                         (i == DEPTH - 1), 1'b0);
        end
        expect_session_end();

        // Reset while a tuple is pending: no write, then a clean session.
        $display("[TB] mid-session reset");
        apply_start(1'b1, 32'h0000_8000);
        t = rand_tuple();
        in_fmt = t.fmt; in_op = t.op; in_rs = t.rs; in_rt = t.rt; in_rd = t.rd;
        in_shamt = t.sh; in_funct = t.fn; in_imm16 = t.i16; in_imm26 = t.i26;
        in_valid = 1'b1;
        #3;
        reset_n = 1'b0;
        tick();
        in_valid = 1'b0;
        check_output("abort_we",    {31'd0, im_we},    32'd0);
        check_output("abort_addr",  im_addr,           32'd0);
        check_output("abort_data",  im_wdata,          32'd0);
        check_output("abort_count", {29'd0, word_count}, 32'd0);
        check_output("abort_busy",  {31'd0, busy},     32'd0);
        check_output("abort_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        tick();
        apply_start(1'b0, 32'h0);
        t = rand_tuple();
        apply_stimulus(t, 1'b1);
        expect_write(32'h3000, model_word(t), 1, 1'b1, 1'b0);
        expect_session_end();

`ifdef INSTR_PACKER_FIELD_CHECK_EN
        // Malformed R tuple is dropped; the next tuple keeps the address.
        $display("[TB] field check");
        apply_start(1'b0, 32'h0);
        apply_stimulus(make_tuple(0, 'h23, 1, 2, 3, 4, 5, 0, 0), 1'b0);
        check_output("bad_we",    {31'd0, im_we},     32'd0);
        check_output("bad_flag",  {31'd0, bad_field}, 32'd1);
        check_output("bad_count", {29'd0, word_count}, 32'd0);
        t = make_tuple(1, 'h08, 3, 4, 0, 0, 0, 'hBEEF, 0);
        apply_stimulus(t, 1'b1);
        expect_write(32'h3000, model_word(t), 1, 1'b1, 1'b0);
        expect_session_end();
`endif

        // Randomized sessions with random gaps between tuples.
        $display("[TB] random sessions");
        for (int s = 0; s < 12; s++) begin
            sel  = 1'($urandom);
            base = $urandom;
            n    = $urandom_range(1, DEPTH - 1);
            tq.delete();
            for (int i = 0; i < n; i++) tq.push_back(rand_tuple());
            apply_start(sel, base);
            if (sel) base = base & 32'hFFFF_FFFC;
            else     base = BASE_ADDR;
            for (int i = 0; i < n; i++) begin
                apply_stimulus(tq[i], (i == n - 1));
                expect_write(base + 32'(4 * i), model_word(tq[i]), i + 1,
                             (i == n - 1), 1'b0);
                if (i != n - 1) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) begin
                        tick();
                        check_idle_cycle("rand_gap");
                    end
                end
            end
            expect_session_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_packer.md
Name: instr_packer

Overview:
- Reverse of the instruction field splitter: takes decoded MIPS field tuples (format, opcode, rs, rt, rd, shamt, funct, imm16, imm26) over a valid/ready handshake.
- Packs each tuple into a 32-bit instruction word and writes it sequentially into the instruction-memory load port, starting at a programmable byte base address.
- Sits between the bench/boot loader and IM. Used to preload programs for P4/P5 CPU runs.

Parameters:
- DEPTH, 1024, maximum words per load session; must be a power of two.
- BASE_ADDR, 32'h0000_3000, default load base byte address, used when start_base_sel=0.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load session
- start_base_sel  input  1  sampled with start: 0 selects BASE_ADDR, 1 selects start_base
- start_base  input  32  alternate base byte address; bits [1:0] are ignored (forced to 0)
- in_valid  input  1  field tuple valid
- in_ready  output  1  packer can accept a tuple
- in_last  input  1  tuple is the final one of the session
- in_fmt  input  2  0=R, 1=I, 2=J, 3=reserved
- in_op  input  6  opcode
- in_rs  input  5  rs field
- in_rt  input  5  rt field
- in_rd  input  5  rd field
- in_shamt  input  5  shamt field
- in_funct  input  6  funct field
- in_imm16  input  16  16-bit immediate
- in_imm26  input  26  26-bit jump target
- im_we  output  1  IM write strobe
- im_addr  output  32  IM write byte address
- im_wdata  output  32  packed instruction word
- word_count  output  log2(DEPTH)+1  words written this session
- busy  output  1  session active
- done  output  1  one-cycle pulse, coincident with the final im_we
- overflow  output  1  sticky; session stopped at DEPTH without in_last

Behaviour:
- Reset values (async on reset_n low): state=IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, word_count=0, busy=0, done=0, overflow=0.
- States and transitions:
  - IDLE: start → LOAD. On that transition, load the address pointer with the selected base, clear word_count and overflow, set busy=1.
  - LOAD: in_ready=1.
  - A handshake (in_valid & in_ready) on the last tuple, or on the tuple that makes word_count reach DEPTH, → DONE.
  - DONE: in_ready=0. Return to IDLE after one cycle; busy falls on entering IDLE.
- start outside IDLE is ignored.
- Packing is combinational from the inputs and registered at the handshake:
  - R: {op, rs, rt, rd, shamt, funct}
  - I: {op, rs, rt, imm16}
  - J: {op, imm26}
  - fmt=3: word 32'h0000_0000 (nop).
- Latency: a handshake in cycle N gives im_we=1 in cycle N+1 with the registered im_addr/im_wdata. im_we is 0 in every cycle without a preceding handshake.
- The address pointer advances by 4 per accepted tuple and wraps modulo 2^32. word_count increments in the same cycle as im_we.
- done=1 in the same cycle as the im_we of the final word.
- Reaching DEPTH without in_last: the DEPTH-th word is written, overflow=1 and done=1 together, and the session ends.
- in_last together with word DEPTH: done=1, overflow=0.
- in_valid is allowed to drop between tuples. Idle cycles produce no writes.
- reset_n asserted mid-session aborts immediately. No im_we is issued for a pending tuple.

Optional Feature:
- Macro: INSTR_PACKER_FIELD_CHECK_EN.
- Defined: a tuple is accepted but NOT written (im_we=0, pointer and count unchanged) when fmt=R with op≠0, or fmt=3. Such a tuple sets a sticky output port bad_field (1 bit, reset 0, cleared on start). If it carries in_last, the session still ends: done pulses in the cycle after the handshake with im_we=0.
- Undefined: no checking; the bad_field port is absent.

Decomposition:
- Package instr_pkg: format enum FMT_R/FMT_I/FMT_J/FMT_RSV, field width constants (OP_W=6, REG_W=5, SHAMT_W=5, FUNCT_W=6, IMM16_W=16, IMM26_W=26), the state enum IDLE/LOAD/DONE, and NOP_WORD.
- One natural sub-module, instr_pack_comb: purely combinational fields→word packer. It is reusable as the exact inverse of the splitter for round-trip checks.

Test Plan:
- Default base, 3 tuples: R(op0,rs8,rt9,rd10,sh0,fn0x20), I(op0x0D,rs0,rt8,imm0x1234), J(op0x02,imm0x0000C00) with last on the third → writes 0x01095020@0x3000, 0x34081234@0x3004, 0x08000C00@0x3008. done with the third write, word_count=3.
- start_base_sel=1, start_base=0x0000_0103 → first im_addr=0x0000_0100.
- in_valid toggling 1,0,1 with in_last on the second tuple → exactly two im_we pulses, each one cycle after its handshake.
- DEPTH=4, 5 tuples offered without last → 4 writes, then overflow=1 and done=1 on the 4th write; in_ready=0 thereafter.
- reset_n low in the cycle after a handshake → no im_we; all outputs at reset values; a new start works normally.
- FIELD_CHECK_EN: R tuple with op=0x23 → no write, bad_field=1, following valid tuple written at the unchanged address.
